// File: rtl/adc_snapshot_ctrl.sv
// adc_snapshot_ctrl: multi-lane ADC snapshot buffer.
// Captures Nti interleaved ADC lanes ({sign, magnitude} per lane) into an
// on-chip memory on a dump request. There are two capture modes:
//   mode 0 - post-trigger one-shot: Depth consecutive samples from the start.
//   mode 1 - circular pre-trigger: the buffer runs continuously until a trig
//            arrives with at least pre_len samples already stored.
// Readback uses a trigger-aligned logical address and has a registered data
// output with one cycle of latency.

module adc_snapshot_ctrl #(
    parameter  int Nti   = 16,
    parameter  int Nadc  = 8,
    parameter  int Depth = 256,
    localparam int Aw    = $clog2(Depth),
    localparam int Lw    = (Nti > 1) ? $clog2(Nti) : 1
) (
    input  logic                     clk_adc,
    input  logic                     rstb,
    input  logic [Nti-1:0][Nadc-1:0] adcout,
    input  logic [Nti-1:0]           adcout_sign,
    input  logic                     dump_start,
    input  logic                     trig,
    input  logic                     mode,
    input  logic [Aw-1:0]            pre_len,
    input  logic [Aw-1:0]            rd_addr,
    input  logic [Lw-1:0]            rd_lane,
    output logic [Nadc:0]            rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [Aw-1:0]            trig_addr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Depth and 1 are held one bit wider than an address so that a full-buffer
    // count (Depth) and the saturated fill level can both be represented.
    localparam logic [Aw:0] DEPTH_C = (Aw+1)'(Depth);
    localparam logic [Aw:0] ONE_C   = {{Aw{1'b0}}, 1'b1};

    // dump_start synchroniser and edge detector
    logic sync1_q;
    logic start_s_q;
    logic start_dly_q;
    logic start_pulse_s;

    // control state
    state_t         state_q,      state_d;
    logic [Aw-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [Aw:0]    fill_q,       fill_d;
    logic [Aw:0]    cnt_q,        cnt_d;
    logic [Aw-1:0]  trig_addr_q,  trig_addr_d;
    logic           mode_sh_q,    mode_sh_d;
    logic [Aw-1:0]  pre_len_sh_q, pre_len_sh_d;
    logic           busy_q,       busy_d;
    logic           done_q,       done_d;
    logic           wr_en_s;
    logic [Aw:0]    rem_s;
    logic           trig_ok_s;

    // storage and read path
    logic [Nti-1:0][Nadc:0] wr_word_s;
    logic [Nti-1:0][Nadc:0] mem_q [Depth];
    logic [Aw-1:0]          rd_base_s;
    logic [Aw-1:0]          rd_phys_s;
    logic [Nadc:0]          rd_data_q;

    // Two-flop synchroniser for the asynchronous dump request plus a delay
    // flop for rising-edge detection.
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            sync1_q     <= 1'b0;
            start_s_q   <= 1'b0;
            start_dly_q <= 1'b0;
        end else begin
            sync1_q     <= dump_start;
            start_s_q   <= sync1_q;
            start_dly_q <= start_s_q;
        end
    end

    // The start pulse is combinational on the synchronised level so the FSM
    // reacts in the same cycle the edge is seen.
    assign start_pulse_s = start_s_q & ~start_dly_q;

    // Captures still to write after the trigger sample; pre_len < Depth, so
    // this never underflows.
    assign rem_s     = DEPTH_C - {1'b0, pre_len_sh_q} - ONE_C;
    assign trig_ok_s = trig && (fill_q >= {1'b0, pre_len_sh_q});

    // Pack the lanes into one memory word, sign bit above each magnitude.
    always_comb begin
        wr_word_s = '0;
        for (int i = 0; i < Nti; i++) begin
            wr_word_s[i] = {adcout_sign[i], adcout[i]};
        end
    end

    // Next-state and datapath-control logic for the capture FSM.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        cnt_d        = cnt_q;
        trig_addr_d  = trig_addr_q;
        mode_sh_d    = mode_sh_q;
        pre_len_sh_d = pre_len_sh_q;
        wr_en_s      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_pulse_s) begin
                    wr_ptr_d     = {Aw{1'b0}};
                    fill_d       = {(Aw+1){1'b0}};
                    mode_sh_d    = mode;
                    pre_len_sh_d = pre_len;
                    if (mode) begin
                        state_d = ST_ARM;
                    end else begin
                        state_d = ST_CAPTURE;
                        cnt_d   = DEPTH_C;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_ARM: begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + {{(Aw-1){1'b0}}, 1'b1};
                if (fill_q == DEPTH_C) begin
                    fill_d = DEPTH_C;
                end else begin
                    fill_d = fill_q + ONE_C;
                end
                // A trigger only counts once enough history is stored.
                if (trig_ok_s) begin
                    trig_addr_d = wr_ptr_q;
                    cnt_d       = rem_s;
                    if (rem_s == {(Aw+1){1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_ARM;
                end
            end

            ST_CAPTURE: begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + {{(Aw-1){1'b0}}, 1'b1};
                if (cnt_q <= ONE_C) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // Control register bank; an asynchronous reset aborts any capture in
    // progress.
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {Aw{1'b0}};
            fill_q       <= {(Aw+1){1'b0}};
            cnt_q        <= {(Aw+1){1'b0}};
            trig_addr_q  <= {Aw{1'b0}};
            mode_sh_q    <= 1'b0;
            pre_len_sh_q <= {Aw{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            cnt_q        <= cnt_d;
            trig_addr_q  <= trig_addr_d;
            mode_sh_q    <= mode_sh_d;
            pre_len_sh_q <= pre_len_sh_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Snapshot memory write port; its contents are deliberately not reset.
    always_ff @(posedge clk_adc) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_word_s;
        end
    end

    // The logical-to-physical mapping wraps naturally in Aw-bit arithmetic.
    assign rd_base_s = mode_sh_q ? (trig_addr_q - pre_len_sh_q) : {Aw{1'b0}};
    assign rd_phys_s = rd_base_s + rd_addr;

    // Registered lane readout. Because the write uses a non-blocking update,
    // reading the word being written in the same cycle returns its old
    // contents.
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            rd_data_q <= {(Nadc+1){1'b0}};
        end else begin
            rd_data_q <= mem_q[rd_phys_s][rd_lane];
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_adc_snapshot_ctrl.sv
// Testbench for adc_snapshot_ctrl (Depth=16, Nti=4, Nadc=8).
// The stimulus process runs the scenarios and pushes expected values, each
// tagged with the cycle it is due, into a scoreboard queue. A monitor on the
// falling clock edge pops each due entry and compares it with the DUT output.
// The reference model records every sample presented on each cycle and
// rebuilds the expected buffer from the capture rules (start cycle, trigger
// cycle and pre_len).

module tb_adc_snapshot_ctrl;

    localparam int NTI   = 4;
    localparam int NADC  = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 2;
    localparam int WW    = NTI * (NADC + 1);
    localparam int HMAX  = 8192;

    logic                     clk;
    logic                     rstb;
    logic [NTI-1:0][NADC-1:0] adcout;
    logic [NTI-1:0]           adcout_sign;
    logic                     dump_start;
    logic                     trig;
    logic                     mode;
    logic [AW-1:0]            pre_len;
    logic [AW-1:0]            rd_addr;
    logic [LW-1:0]            rd_lane;
    logic [NADC:0]            rd_data;
    logic                     busy;
    logic                     done;
    logic [AW-1:0]            trig_addr;

    adc_snapshot_ctrl #(.Nti(NTI), .Nadc(NADC), .Depth(DEPTH)) dut (
        .clk_adc    (clk),
        .rstb       (rstb),
        .adcout     (adcout),
        .adcout_sign(adcout_sign),
        .dump_start (dump_start),
        .trig       (trig),
        .mode       (mode),
        .pre_len    (pre_len),
        .rd_addr    (rd_addr),
        .rd_lane    (rd_lane),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int kind;   // 0 rd_data, 1 busy, 2 done, 3 trig_addr
        int expv;
    } exp_t;

    exp_t          sb[$];
    int            checks;
    int            failures;
    int            cyc;
    bit            ramp_en;
    logic [WW-1:0] hist   [HMAX];
    logic [WW-1:0] expbuf [DEPTH];

    function automatic string kname(input int k);
        case (k)
            0:       return "rd_data";
            1:       return "busy";
            2:       return "done";
            3:       return "trig_addr";
            default: return "unknown";
        endcase
    endfunction

    function automatic int lane_of(input logic [WW-1:0] w, input int l);
        logic [NADC:0] v;
        v = w[l*(NADC+1) +: (NADC+1)];
        return int'(v);
    endfunction

    task automatic sb_push(input int due, input int kind, input int expv);
        exp_t it;
        int   idx;
        it.due  = due;
        it.kind = kind;
        it.expv = expv;
        idx     = sb.size();
        while (idx > 0 && sb[idx-1].due > due) idx--;
        sb.insert(idx, it);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Sample driver: a new lane word on every cycle, recorded by cycle number.
    initial begin
        logic [WW-1:0] w;
        logic [7:0]    v;
        cyc         = 0;
        adcout      = '0;
        adcout_sign = '0;
        hist[0]     = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            w   = '0;
            for (int i = 0; i < NTI; i++) begin
                if (ramp_en) v = 8'((cyc + i) % 256);
                else         v = 8'($urandom_range(0, 255));
                adcout[i]      = v;
                adcout_sign[i] = ramp_en ? v[0] : 1'($urandom_range(0, 1));
                w[i*(NADC+1) +: (NADC+1)] = {adcout_sign[i], adcout[i]};
            end
            if (cyc < HMAX) hist[cyc] = w;
        end
    end

    // Monitor: compare every scoreboard entry due in the current cycle.
    initial begin
        exp_t it;
        int   act;
        checks   = 0;
        failures = 0;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it = sb.pop_front();
                case (it.kind)
                    0:       act = int'(rd_data);
                    1:       act = int'(busy);
                    2:       act = int'(done);
                    3:       act = int'(trig_addr);
                    default: act = -1;
                endcase
                checks++;
                if (it.due != cyc || act !== it.expv) begin
                    failures++;
                    $display("FAIL %s: actual=%0d expected=%0d cycle=%0d due=%0d",
                             kname(it.kind), act, it.expv, cyc, it.due);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // One capture: the request is raised now; t1/t2 are ARM-cycle indices at
    // which trig pulses (t1 < 0 means none). noise adds ignored events.
    task automatic do_capture(input bit m, input int pl, input int t1,
                              input int t2, input bit noise);
        int d, f, tcyc, first, done_c, ta, fill1;
        mode       = m;
        pre_len    = pl[AW-1:0];
        dump_start = 1'b1;
        d          = cyc;
        f          = d + 3;
        ta         = 0;
        if (!m) begin
            first  = f;
            done_c = f + DEPTH;
        end else begin
            fill1 = (t1 > DEPTH) ? DEPTH : t1;
            if (t1 >= 0 && fill1 >= pl) begin
                tcyc = f + t1;
                ta   = t1 % DEPTH;
            end else begin
                tcyc = f + t2;
                ta   = t2 % DEPTH;
            end
            first  = tcyc - pl;
            done_c = tcyc + DEPTH - pl;
        end
        while (cyc <= done_c) begin
            dump_start = (cyc < d + 3) ? 1'b1 : 1'b0;
            trig       = 1'b0;
            if (m) trig = (t1 >= 0 && cyc == f + t1) || (cyc == f + t2);
            if (noise) begin
                if (cyc >= f + 4 && cyc < f + 8) dump_start = 1'b1;
                if (cyc == f + 1) begin
                    mode    = ~m;
                    pre_len = AW'($urandom_range(0, DEPTH - 1));
                end
                if (!m && (cyc == f + 6 || cyc == f + 9)) trig = 1'b1;
            end
            if (cyc == f - 1) sb_push(cyc, 1, 0);
            if (cyc == f) begin
                sb_push(cyc, 1, 1);
                sb_push(cyc, 2, 0);
            end
            if (cyc == done_c - 1) begin
                sb_push(cyc, 1, 1);
                sb_push(cyc, 2, 0);
            end
            if (cyc == done_c) begin
                sb_push(cyc, 1, 0);
                sb_push(cyc, 2, 1);
                if (m) sb_push(cyc, 3, ta);
            end
            tick();
        end
        trig       = 1'b0;
        dump_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) expbuf[k] = hist[first + k];
    endtask

    // Read back every logical address on a random lane, with trig noise.
    task automatic read_all();
        int lane;
        for (int k = 0; k < DEPTH + 4; k++) begin
            int a;
            a       = (k < DEPTH) ? k : $urandom_range(0, DEPTH - 1);
            lane    = (k < DEPTH && k % 3 == 0) ? 2 : $urandom_range(0, NTI - 1);
            rd_addr = a[AW-1:0];
            rd_lane = lane[LW-1:0];
            trig    = 1'($urandom_range(0, 1));
            sb_push(cyc + 1, 0, lane_of(expbuf[a], lane));
            tick();
        end
        trig = 1'b0;
        sb_push(cyc, 2, 1);
        sb_push(cyc, 1, 0);
        tick();
    endtask

    // Scenario sequence.
    initial begin
        int d, f, m, pl, t1, t2;
        rstb       = 1'b0;
        dump_start = 1'b0;
        trig       = 1'b0;
        mode       = 1'b0;
        pre_len    = '0;
        rd_addr    = '0;
        rd_lane    = '0;
        ramp_en    = 1'b1;
        tick();
        tick();
        sb_push(cyc, 1, 0);
        sb_push(cyc, 2, 0);
        sb_push(cyc, 3, 0);
        sb_push(cyc, 0, 0);
        tick();
        rstb = 1'b1;
        tick();
        tick();

        // Mode 0 ramp with ignored start/trig/mode events during capture.
        do_capture(1'b0, 0, -1, 0, 1'b1);
        read_all();
        ramp_en = 1'b0;

        // Mode 1: pre_len 5, trig 40 cycles after arming (with noise).
        do_capture(1'b1, 5, -1, 40, 1'b1);
        read_all();

        // Early trig ignored, later trig at fill 12 accepted.
        do_capture(1'b1, 10, 2, 12, 1'b0);
        read_all();

        // pre_len 0 with a trigger on the first ARM cycle.
        do_capture(1'b1, 0, -1, 0, 1'b0);
        read_all();

        // pre_len Depth-1: done one cycle after trig.
        do_capture(1'b1, DEPTH - 1, -1, 20, 1'b0);
        read_all();

        // Reset 7 cycles into a mode-0 capture.
        mode       = 1'b0;
        dump_start = 1'b1;
        d          = cyc;
        f          = d + 3;
        while (cyc < f + 7) begin
            dump_start = (cyc < d + 3) ? 1'b1 : 1'b0;
            tick();
        end
        rstb = 1'b0;
        sb_push(cyc, 1, 0);
        sb_push(cyc, 2, 0);
        sb_push(cyc, 3, 0);
        sb_push(cyc, 0, 0);
        tick();
        sb_push(cyc, 1, 0);
        tick();
        rstb = 1'b1;
        tick();
        tick();
        do_capture(1'b0, 0, -1, 0, 1'b0);
        read_all();

        // Randomised captures.
        for (int r = 0; r < 6; r++) begin
            m  = $urandom_range(0, 1);
            pl = $urandom_range(0, DEPTH - 1);
            if (m == 0) begin
                do_capture(1'b0, pl, -1, 0, 1'b0);
            end else begin
                t1 = $urandom_range(0, 29);
                t2 = ((t1 + 1 > pl) ? t1 + 1 : pl) + $urandom_range(0, 7);
                do_capture(1'b1, pl, t1, t2, 1'b0);
            end
            read_all();
        end

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual=%0d pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_snapshot_ctrl.md
# adc_snapshot_ctrl

Parametrised multi-lane ADC snapshot buffer for the digital core. It captures `Nti` time-interleaved ADC lanes (magnitude plus sign) into an on-chip memory on a dump request. It supports a post-trigger one-shot mode and a circular pre-trigger mode with a programmable pre-trigger length. The buffer is read back one lane at a time through a registered, trigger-aligned read port that JTAG registers drive.

## Interface
- `Nti`, 16, number of ADC lanes captured per word
- `Nadc`, 8, magnitude bits per lane; stored lane width is `Nadc+1` (sign in MSB)
- `Depth`, 256, words per buffer; power of two, ≥4; `Aw = $clog2(Depth)`
- `clk_adc`  in  1  capture/readout clock (ADC retiming clock)
- `rstb`  in  1  reset; one clock; reset is asynchronous and active-low
- `adcout`  in  `Nadc` × `[Nti-1:0]`  ADC magnitudes, valid every `clk_adc` cycle
- `adcout_sign`  in  `Nti`  ADC signs
- `dump_start`  in  1  dump request, asynchronous to `clk_adc` (pad/JTAG level)
- `trig`  in  1  synchronous capture trigger pulse (pre-trigger mode only)
- `mode`  in  1  0 = post-trigger one-shot, 1 = circular pre-trigger
- `pre_len`  in  `Aw`  samples kept before trigger (mode 1)
- `rd_addr`  in  `Aw`  logical read address; 0 = oldest captured sample
- `rd_lane`  in  `$clog2(Nti)`  lane select for readout
- `rd_data`  out  `Nadc+1`  `{sign, magnitude}` of selected lane/word
- `busy`  out  1  high in ARM or CAPTURE
- `done`  out  1  capture complete, buffer valid
- `trig_addr`  out  `Aw`  physical write address at the trigger cycle

## Operation
- `dump_start` passes through a 2-flop synchroniser to `start_s`. `start_pulse` = `start_s & ~start_s_d`, a one-cycle rising-edge pulse.
- Stored word = concatenation over lanes of `{adcout_sign[i], adcout[i]}`. Width is `Nti*(Nadc+1)`. One write per cycle while writing.
- `mode` and `pre_len` are sampled into shadow registers only on `start_pulse`. Changes at any other time have no effect.
- FSM states are IDLE, ARM, CAPTURE and DONE:
  - IDLE/DONE + `start_pulse`: `done`←0, `wr_ptr`←0, `fill`←0.
    - Mode 0: go to CAPTURE with count `Depth`.
    - Mode 1: go to ARM.
  - ARM: write every cycle at `wr_ptr`, then `wr_ptr`++ mod `Depth`. `fill` saturates at `Depth`.
    - `trig` with `fill ≥ pre_len`: latch `trig_addr`←`wr_ptr`, write this cycle's sample, go to CAPTURE with remaining count `Depth-pre_len-1`. If the remaining count is 0, go directly to DONE.
    - `trig` with `fill < pre_len`: ignored.
  - CAPTURE: write and increment each cycle. At the last write go to DONE; `done`←1 the next cycle.
  - DONE: hold `done`=1 and memory contents. A new `start_pulse` re-arms.
- `trig` outside ARM is ignored. `start_pulse` in ARM/CAPTURE is ignored (no restart). Falling `dump_start` has no effect.
- Read base: mode 0 base = 0; mode 1 base = `trig_addr - pre_len` mod `Depth`.
- Physical read address = `(base + rd_addr)` mod `Depth`, i.e. wrap-around is natural `Aw`-bit arithmetic.
- Reads are allowed in any state. A read of the address being written in the same cycle returns the old contents (read-before-write).
- Reset: FSM←IDLE; `busy`, `done`, `trig_addr`, `rd_data`, synchroniser flops, `wr_ptr` and `fill` ←0. Memory array is not reset. Reset mid-capture aborts cleanly; the next `start_pulse` behaves as from power-up.

## Timing
- `dump_start` rising before clock edge N → `start_pulse` in cycle N+2 (2 cycles synchroniser, 0 cycles edge detect).
- The first write occurs in cycle N+3, the first ARM/CAPTURE cycle.
- `busy` is registered: high from N+3 until the cycle after the last write.
- Mode 0: exactly `Depth` consecutive samples, cycles N+3 … N+2+`Depth`. `done` rises at N+3+`Depth`.
- Mode 1: the sample present in the `trig` cycle is stored at `trig_addr` = logical address `pre_len`. `done` rises `Depth-pre_len` cycles after the trig cycle.
- `rd_data` has a 1-cycle latency from `rd_addr`/`rd_lane` (registered output).

## Test plan
- **Mode 0 ramp:** `Depth`=16, `Nti`=4. Drive lane i = (cycle+i) mod 256 with sign = bit0. Pulse `dump_start`. Require `done` exactly 16 cycles after the first write; `rd_addr` k, lane 2 returns the first-write value +k+2; `rd_data` lags the address by 1 cycle.
- **Mode 1 pre-trigger:** `Depth`=16, `pre_len`=5. Arm, then assert `trig` 40 cycles later. Require logical address 5 = trig-cycle sample, address 0 = sample 5 cycles earlier, address 15 = sample 10 cycles after trig; `trig_addr` = 40 mod 16 = 8; read base wraps to 3.
- **Early trigger:** `pre_len`=10, `trig` on the 3rd ARM cycle. Require it is ignored (still ARM); a second `trig` at `fill`=12 is accepted.
- **Boundaries:**
  - `pre_len`=0: trigger on the first ARM cycle is accepted; trig sample at logical 0.
  - `pre_len`=`Depth-1`: `done` rises 1 cycle after trig.
- **Ignored events:** `start_pulse` and a level toggle during CAPTURE leave the capture unaltered; `trig` in IDLE/DONE has no effect; a `mode` change during ARM does not change behaviour.
- **Reset mid-capture:** assert `rstb`=0 asynchronously 7 cycles into CAPTURE. Require all outputs 0 immediately; after release, a fresh dump completes a full `Depth` capture correctly.
